// File: rtl/mul_acc_pkg.sv
// rtl/mul_acc_pkg.sv - shared state encoding and default widths for the accumulate stage
package mul_acc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } mul_acc_state_e;

    localparam int IN_WIDTH_DEF  = 32;
    localparam int ACC_WIDTH_DEF = 40;
    localparam int CNT_WIDTH_DEF = 8;

endpackage

// File: rtl/acc_sat_add.sv
// rtl/acc_sat_add.sv - combinational accumulator adder, wrapping or saturating (MUL_ACC_SATURATE_EN)
module acc_sat_add #(
    parameter int WIDTH = 40
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    logic [WIDTH:0] full_sum;

    assign full_sum = {1'b0, a_i} + {1'b0, b_i};
    assign carry_o  = full_sum[WIDTH];

`ifdef MUL_ACC_SATURATE_EN
    // An all-ones accumulator can only stay all-ones, so clamping holds for the rest of the burst.
    assign sum_o = full_sum[WIDTH] ? {WIDTH{1'b1}} : full_sum[WIDTH-1:0];
`else
    assign sum_o = full_sum[WIDTH-1:0];
`endif

endmodule

// File: rtl/mul_acc_stage.sv
// rtl/mul_acc_stage.sv - burst accumulate stage behind the multiplier PE; io_ovf exists only with MUL_ACC_SATURATE_EN
module mul_acc_stage
    import mul_acc_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [IN_WIDTH-1:0]  io_inputs_0,
    input  logic                 io_in_valid,
    output logic                 io_in_ready,
    input  logic [CNT_WIDTH-1:0] io_len,
    input  logic                 io_clear,
    output logic [ACC_WIDTH-1:0] io_outs_0,
    output logic                 io_out_valid,
    input  logic                 io_out_ready
`ifdef MUL_ACC_SATURATE_EN
    ,
    output logic                 io_ovf
`endif
);

    mul_acc_state_e       state_q;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] len_q;
    logic [CNT_WIDTH-1:0] len_d;
    logic [ACC_WIDTH-1:0] out_q;
    logic                 out_valid_q;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic                 add_carry;
`ifdef MUL_ACC_SATURATE_EN
    logic                 ovf_q;
`endif

    assign prod_ext = ACC_WIDTH'(io_inputs_0);
    assign cnt_d    = cnt_q + CNT_WIDTH'(1);
    // A zero length would never terminate the burst, so it behaves as a single beat.
    assign len_d    = (io_len == '0) ? CNT_WIDTH'(1) : io_len;

    acc_sat_add #(
        .WIDTH (ACC_WIDTH)
    ) u_add (
        .a_i     (acc_q),
        .b_i     (prod_ext),
        .sum_o   (acc_d),
        .carry_o (add_carry)
    );

    assign io_in_ready  = (state_q != HOLD);
    assign io_outs_0    = out_q;
    assign io_out_valid = out_valid_q;
`ifdef MUL_ACC_SATURATE_EN
    assign io_ovf       = ovf_q;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef MUL_ACC_SATURATE_EN
            ovf_q       <= 1'b0;
`endif
        end else if (io_clear) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef MUL_ACC_SATURATE_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (io_in_valid) begin
                        acc_q <= prod_ext;
                        cnt_q <= CNT_WIDTH'(1);
                        len_q <= len_d;
`ifdef MUL_ACC_SATURATE_EN
                        ovf_q <= 1'b0;
`endif
                        if (len_d == CNT_WIDTH'(1)) begin
                            state_q     <= HOLD;
                            out_q       <= prod_ext;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (io_in_valid) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
`ifdef MUL_ACC_SATURATE_EN
                        ovf_q <= ovf_q | add_carry;
`endif
                        if (cnt_d == len_q) begin
                            state_q     <= HOLD;
                            out_q       <= acc_d;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (io_out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_acc_stage.sv
// tb/tb_mul_acc_stage.sv - directed self-checking bench for mul_acc_stage
module tb_mul_acc_stage;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] io_inputs_0 = '0;
    logic        io_in_valid = 1'b0;
    logic [7:0]  io_len = '0;
    logic        io_clear = 1'b0;
    logic        io_out_ready = 1'b1;

    logic        in_ready;
    logic [39:0] outs;
    logic        out_valid;
    logic        in_ready32;
    logic [31:0] outs32;
    logic        out_valid32;
`ifdef MUL_ACC_SATURATE_EN
    logic        ovf;
    logic        ovf32;
`endif

    int n_checks = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    mul_acc_stage u_dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .io_inputs_0  (io_inputs_0),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (in_ready),
        .io_len       (io_len),
        .io_clear     (io_clear),
        .io_outs_0    (outs),
        .io_out_valid (out_valid),
        .io_out_ready (io_out_ready)
`ifdef MUL_ACC_SATURATE_EN
        ,
        .io_ovf       (ovf)
`endif
    );

    mul_acc_stage #(
        .ACC_WIDTH (32)
    ) u_dut32 (
        .clock        (clock),
        .reset_n      (reset_n),
        .io_inputs_0  (io_inputs_0),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (in_ready32),
        .io_len       (io_len),
        .io_clear     (io_clear),
        .io_outs_0    (outs32),
        .io_out_valid (out_valid32),
        .io_out_ready (io_out_ready)
`ifdef MUL_ACC_SATURATE_EN
        ,
        .io_ovf       (ovf32)
`endif
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_checks++; if (outs !== 40'h0) begin n_fail++; $display("FAIL reset_outs got %h want 0", outs); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
`ifdef MUL_ACC_SATURATE_EN
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_basic_burst();
        io_len = 8'd4;
        io_out_ready = 1'b1;
        io_in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            io_inputs_0 = 32'(i);
            tick();
            if (i == 3) begin
                n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL burst_early_valid got %b want 0", out_valid); end
            end
        end
        io_in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL burst_valid got %b want 1", out_valid); end
        n_checks++; if (outs !== 40'd10) begin n_fail++; $display("FAIL burst_sum got %0d want 10", outs); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL burst_hold_in_ready got %b want 0", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL burst_taken_valid got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL burst_idle_in_ready got %b want 1", in_ready); end
        n_checks++; if (outs !== 40'd10) begin n_fail++; $display("FAIL burst_outs_kept got %0d want 10", outs); end
    endtask

    task automatic test_len_zero();
        io_len = 8'd0;
        io_inputs_0 = 32'hFFFF_FFFF;
        io_in_valid = 1'b1;
        tick();
        io_in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL len0_valid got %b want 1", out_valid); end
        n_checks++; if (outs !== 40'h00_FFFF_FFFF) begin n_fail++; $display("FAIL len0_outs got %h want 00ffffffff", outs); end
        tick();
    endtask

    task automatic test_backpressure();
        io_out_ready = 1'b0;
        io_len = 8'd2;
        io_in_valid = 1'b1;
        io_inputs_0 = 32'd5;
        tick();
        io_inputs_0 = 32'd7;
        tick();
        io_inputs_0 = 32'd100;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b want 1", k, out_valid); end
            n_checks++; if (outs !== 40'd12) begin n_fail++; $display("FAIL bp_outs[%0d] got %0d want 12", k, outs); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b want 0", k, in_ready); end
            if (k < 2) tick();
        end
        io_out_ready = 1'b1;
        tick();
        io_in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_taken_valid got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle_in_ready got %b want 1", in_ready); end
        n_checks++; if (outs !== 40'd12) begin n_fail++; $display("FAIL bp_outs_kept got %0d want 12", outs); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_extra_beat got %b want 0", out_valid); end
    endtask

    task automatic test_gaps();
        io_len = 8'd3;
        io_in_valid = 1'b1;
        io_inputs_0 = 32'd4;
        tick();
        io_in_valid = 1'b0;
        repeat (2) tick();
        io_in_valid = 1'b1;
        io_inputs_0 = 32'd5;
        tick();
        io_in_valid = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL gap_early_valid got %b want 0", out_valid); end
        io_in_valid = 1'b1;
        io_inputs_0 = 32'd6;
        tick();
        io_in_valid = 1'b0;
        n_checks++; if (outs !== 40'd15) begin n_fail++; $display("FAIL gap_sum got %0d want 15", outs); end
        tick();
    endtask

    task automatic test_clear();
        io_len = 8'd3;
        io_in_valid = 1'b1;
        io_inputs_0 = 32'd9;
        repeat (2) tick();
        io_clear = 1'b1;
        tick();
        io_clear = 1'b0;
        io_in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_valid got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL clear_in_ready got %b want 1", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_no_output got %b want 0", out_valid); end
        io_len = 8'd1;
        io_inputs_0 = 32'd3;
        io_in_valid = 1'b1;
        tick();
        io_in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clear_next_valid got %b want 1", out_valid); end
        n_checks++; if (outs !== 40'd3) begin n_fail++; $display("FAIL clear_next_outs got %0d want 3", outs); end
        tick();
    endtask

    task automatic test_overflow();
        io_len = 8'd2;
        io_in_valid = 1'b1;
        io_inputs_0 = 32'hFFFF_FFFF;
        tick();
        io_inputs_0 = 32'd2;
        tick();
        io_in_valid = 1'b0;
        n_checks++; if (out_valid32 !== 1'b1) begin n_fail++; $display("FAIL ovf32_valid got %b want 1", out_valid32); end
`ifdef MUL_ACC_SATURATE_EN
        n_checks++; if (outs32 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat32_outs got %h want ffffffff", outs32); end
        n_checks++; if (ovf32 !== 1'b1) begin n_fail++; $display("FAIL sat32_ovf got %b want 1", ovf32); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL sat40_ovf got %b want 0", ovf); end
`else
        n_checks++; if (outs32 !== 32'd1) begin n_fail++; $display("FAIL wrap32_outs got %h want 00000001", outs32); end
`endif
        n_checks++; if (outs !== 40'h01_0000_0001) begin n_fail++; $display("FAIL wide40_outs got %h want 0100000001", outs); end
        tick();
        io_len = 8'd1;
        io_inputs_0 = 32'd5;
        io_in_valid = 1'b1;
        tick();
        io_in_valid = 1'b0;
        n_checks++; if (outs32 !== 32'd5) begin n_fail++; $display("FAIL ovf32_next_outs got %0d want 5", outs32); end
`ifdef MUL_ACC_SATURATE_EN
        n_checks++; if (ovf32 !== 1'b0) begin n_fail++; $display("FAIL ovf32_cleared got %b want 0", ovf32); end
`endif
        tick();
    endtask

    task automatic test_back_to_back();
        io_len = 8'd1;
        io_out_ready = 1'b1;
        io_in_valid = 1'b1;
        io_inputs_0 = 32'd6;
        tick();
        n_checks++; if (outs !== 40'd6) begin n_fail++; $display("FAIL b2b_first got %0d want 6", outs); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_hold_in_ready got %b want 0", in_ready); end
        io_inputs_0 = 32'd8;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_valid got %b want 0", out_valid); end
        n_checks++; if (outs !== 40'd6) begin n_fail++; $display("FAIL b2b_gap_outs got %0d want 6", outs); end
        tick();
        io_in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second_valid got %b want 1", out_valid); end
        n_checks++; if (outs !== 40'd8) begin n_fail++; $display("FAIL b2b_second got %0d want 8", outs); end
        tick();
    endtask

    task automatic test_max_len();
        io_len = 8'd255;
        io_inputs_0 = 32'd1;
        io_in_valid = 1'b1;
        repeat (254) tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL maxlen_early_valid got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL maxlen_in_ready got %b want 1", in_ready); end
        tick();
        io_in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL maxlen_valid got %b want 1", out_valid); end
        n_checks++; if (outs !== 40'd255) begin n_fail++; $display("FAIL maxlen_sum got %0d want 255", outs); end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        io_len = 8'd5;
        io_in_valid = 1'b1;
        io_inputs_0 = 32'd10;
        tick();
        io_inputs_0 = 32'd20;
        tick();
        io_in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if (outs !== 40'h0) begin n_fail++; $display("FAIL rst_mid_outs got %h want 0", outs); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready); end
        @(negedge clock);
        reset_n = 1'b1;
        io_len = 8'd1;
        io_inputs_0 = 32'd4;
        io_in_valid = 1'b1;
        tick();
        io_in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_next_valid got %b want 1", out_valid); end
        n_checks++; if (outs !== 40'd4) begin n_fail++; $display("FAIL rst_next_outs got %0d want 4", outs); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_len_zero();
        test_backpressure();
        test_gaps();
        test_clear();
        test_overflow();
        test_back_to_back();
        test_max_len();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_acc_stage.md
Name: mul_acc_stage

Overview:
- Sequential accumulate stage directly downstream of the CGRA combinational multiplier PE.
- Consumes the unsigned product stream and sums io_len consecutive products into a wider accumulator.
- Presents one result per burst on a valid/ready output; this gives the datapath its pipelined MAC.

Parameters:
- IN_WIDTH, 32: product width; matches the multiplier output width.
- ACC_WIDTH, 40: accumulator and result width; must be >= IN_WIDTH.
- CNT_WIDTH, 8: width of the burst length and beat counter.

Ports:
- clock  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- io_inputs_0  input  IN_WIDTH  unsigned product from the multiplier.
- io_in_valid  input  1  product beat valid.
- io_in_ready  output  1  stage accepts a beat.
- io_len  input  CNT_WIDTH  beats per burst; sampled on the first beat only; 0 is treated as 1.
- io_clear  input  1  synchronous abort.
- io_outs_0  output  ACC_WIDTH  accumulated result, driven from a register.
- io_out_valid  output  1  result valid.
- io_out_ready  input  1  downstream accepts the result.
- io_ovf  output  1  sticky overflow flag; present only with MUL_ACC_SATURATE_EN.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, acc=0, cnt=0, len_q=0, io_outs_0=0, io_out_valid=0, io_ovf=0.
- io_in_ready: combinational from state. It is 1 in IDLE and ACC, 0 in HOLD. Reset enters IDLE, so it is 1 after reset.
- Beat accepted: io_in_valid & io_in_ready.
- State IDLE, on an accepted beat:
  - acc <= zero-extended product; cnt <= 1; len_q <= max(io_len, 1).
  - Next state: HOLD if len_q==1, else ACC.
- State ACC, on an accepted beat:
  - acc <= acc + zero-extended product; cnt <= cnt+1.
  - If cnt+1 == len_q, go to HOLD.
  - With no beat, state and acc are held; gaps in io_in_valid are allowed.
- State HOLD:
  - io_out_valid=1 and io_outs_0=acc.
  - On io_out_ready: go to IDLE, io_out_valid <= 0. io_outs_0 keeps its last value.
  - No beat is accepted in HOLD, including the cycle the result is taken.
- Latency and throughput:
  - Result is visible the cycle after the last beat.
  - Minimum period is len+1 cycles per burst.
- io_clear (priority over everything except reset):
  - Next state IDLE; acc=0, cnt=0, io_out_valid=0, io_ovf=0.
  - Any beat presented in that cycle is dropped.
  - A pending result in HOLD is discarded.
- Arithmetic: unsigned throughout. Without the feature, overflow wraps modulo 2^ACC_WIDTH.
- Counter: cnt never exceeds len_q. len_q = 2^CNT_WIDTH-1 is legal.
- Reset mid-burst: partial sum discarded; the next beat starts a fresh burst.

Optional Feature:
- Macro: MUL_ACC_SATURATE_EN.
- Defined:
  - Adder result is computed in ACC_WIDTH+1 bits. On carry-out, acc clamps to all-ones and io_ovf <= 1.
  - io_ovf is sticky until the first beat of the next burst, io_clear, or reset.
  - Once clamped, acc stays at all-ones for the rest of the burst.
- Undefined: wrap-around arithmetic and no io_ovf port.

Decomposition:
- Shared package mul_acc_pkg:
  - State encoding typedef: IDLE=2'd0, ACC=2'd1, HOLD=2'd2.
  - Default width constants IN_WIDTH/ACC_WIDTH/CNT_WIDTH.
- Sub-module acc_sat_add: combinational ACC_WIDTH adder, wrap or saturate under the macro, with a carry-out. The FSM, counter and registers stay in the top.

Test Plan:
- Default params, len=4, products 1,2,3,4 on consecutive cycles, io_out_ready=1: io_out_valid=1 one cycle after beat 4 with io_outs_0=10; io_in_ready=0 that cycle, then 1.
- len=0, product 0xFFFF_FFFF: treated as len=1; io_outs_0=0x00_FFFF_FFFF the next cycle.
- len=2, products 5,7 with io_out_ready=0 for 3 cycles: io_outs_0=12 with valid held stable; io_in_ready=0 throughout; drops to IDLE on the ready cycle.
- len=3, beats 9,9, then io_clear=1 with io_in_valid=1: no output, acc=0; next burst len=1, product 3 gives io_outs_0=3.
- ACC_WIDTH=32, len=2, products 0xFFFF_FFFF and 2:
  - Without the macro: io_outs_0=1.
  - With MUL_ACC_SATURATE_EN: io_outs_0=0xFFFF_FFFF and io_ovf=1.
- reset_n asserted mid-ACC (len=5 after 2 beats): outputs 0 immediately, asynchronously; after release, len=1, product 4 gives io_outs_0=4.
